// File: rtl/fp_exception_unit_pkg.sv
// fp_exception_unit_pkg: op codes, exception codes and flag mapping shared by the exception unit.
package fp_exception_unit_pkg;
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } fp_op_e;

    typedef enum logic [1:0] {
        EXC_NONE    = 2'b00,
        EXC_INVALID = 2'b01,
        EXC_DIVZ    = 2'b10,
        EXC_SPECIAL = 2'b11
    } exc_e;

    localparam int FLAG_W = 3;

    // Sticky flag layout is {special, divzero, invalid}
    function automatic logic [FLAG_W-1:0] exc_flag(exc_e e);
        return {e == EXC_SPECIAL, e == EXC_DIVZ, e == EXC_INVALID};
    endfunction
endpackage

// File: rtl/fp_classify.sv
// fp_classify: splits a minifloat operand into sign and NaN/inf/zero classes.
module fp_classify #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3
) (
    input  logic [EXP_W+MAN_W:0] i_op,
    output logic                 o_sign,
    output logic                 o_is_nan,
    output logic                 o_is_inf,
    output logic                 o_is_zero
);
    logic w_exp_ones;
    logic w_exp_zero;
    logic w_man_zero;

    assign w_exp_ones = &i_op[MAN_W +: EXP_W];
    assign w_exp_zero = ~|i_op[MAN_W +: EXP_W];
    assign w_man_zero = ~|i_op[MAN_W-1:0];
    assign o_sign     = i_op[EXP_W+MAN_W];
    assign o_is_nan   = w_exp_ones && !w_man_zero;
    assign o_is_inf   = w_exp_ones && w_man_zero;
    assign o_is_zero  = w_exp_zero && w_man_zero;
endmodule

// File: rtl/fp_exception_unit.sv
// fp_exception_unit: pipelined exception detector for the minifloat FPU with sticky flags and a
// saturating exception counter behind a one-deep registered valid/ready stage.
module fp_exception_unit
    import fp_exception_unit_pkg::*;
#(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    parameter int CNT_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [1:0]             i_fp_operation,
    input  logic [EXP_W+MAN_W:0]   i_op_a,
    input  logic [EXP_W+MAN_W:0]   i_op_b,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic                   o_op_is_exception,
    output logic [1:0]             o_fp_exce,
    output logic [EXP_W+MAN_W:0]   o_default_result,
    output logic [FLAG_W-1:0]      o_sticky_flags,
    output logic [CNT_W-1:0]       o_exc_count,
    input  logic                   i_flag_clr
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic              w_a_sign, w_a_nan, w_a_inf, w_a_zero;
    logic              w_b_sign, w_b_nan, w_b_inf, w_b_zero;
    logic              w_b_sign_eff;
    logic              w_sign_xor;
    logic              w_in_fire;
    exc_e              w_exc;
    logic [W-1:0]      w_res;
    logic [W-1:0]      w_qnan;
    logic [FLAG_W-1:0] w_flags_base;
    logic [CNT_W-1:0]  w_cnt_base;

    logic              r_valid;
    exc_e              r_exc;
    logic [W-1:0]      r_res;
    logic [FLAG_W-1:0] r_flags;
    logic [CNT_W-1:0]  r_cnt;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .i_op(i_op_a), .o_sign(w_a_sign), .o_is_nan(w_a_nan), .o_is_inf(w_a_inf), .o_is_zero(w_a_zero)
    );
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .i_op(i_op_b), .o_sign(w_b_sign), .o_is_nan(w_b_nan), .o_is_inf(w_b_inf), .o_is_zero(w_b_zero)
    );

    assign o_in_ready   = !r_valid || i_out_ready;
    assign w_in_fire    = i_in_valid && o_in_ready;
    assign w_b_sign_eff = w_b_sign ^ (i_fp_operation == OP_SUB);
    assign w_sign_xor   = w_a_sign ^ w_b_sign;
    assign w_qnan       = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    always_comb begin
        w_exc = EXC_NONE;
        w_res = '0;
        if (w_a_nan || w_b_nan) begin
            w_exc = EXC_INVALID;
            w_res = w_qnan;
        end else begin
            case (i_fp_operation)
                OP_ADD, OP_SUB: begin
                    if (w_a_inf && w_b_inf && (w_a_sign != w_b_sign_eff)) begin
                        w_exc = EXC_INVALID;
                        w_res = w_qnan;
                    end else if (w_a_inf || w_b_inf) begin
                        w_exc = EXC_SPECIAL;
                        w_res = {w_a_inf ? w_a_sign : w_b_sign_eff, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end
                end
                OP_MUL: begin
                    if ((w_a_zero && w_b_inf) || (w_a_inf && w_b_zero)) begin
                        w_exc = EXC_INVALID;
                        w_res = w_qnan;
                    end else if (w_a_inf || w_b_inf) begin
                        w_exc = EXC_SPECIAL;
                        w_res = {w_sign_xor, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end
                end
                default: begin
                    if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
                        w_exc = EXC_INVALID;
                        w_res = w_qnan;
                    end else if (w_a_inf || w_b_zero) begin
                        w_exc = w_a_inf ? EXC_SPECIAL : EXC_DIVZ;
                        w_res = {w_sign_xor, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else if (w_b_inf) begin
                        w_exc = EXC_SPECIAL;
                        w_res = {w_sign_xor, {(W-1){1'b0}}};
                    end
                end
            endcase
        end
    end

    // A same-cycle clear is applied before the new exception is accumulated
    assign w_flags_base = i_flag_clr ? '0 : r_flags;
    assign w_cnt_base   = i_flag_clr ? '0 : r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_exc   <= EXC_NONE;
            r_res   <= '0;
            r_flags <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_in_fire) begin
                r_valid <= 1'b1;
                r_exc   <= w_exc;
                r_res   <= w_res;
            end else if (i_out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_in_fire && (w_exc != EXC_NONE)) begin
                r_flags <= w_flags_base | exc_flag(w_exc);
                r_cnt   <= (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_W'(1);
            end else if (i_flag_clr) begin
                r_flags <= '0;
                r_cnt   <= '0;
            end
        end
    end

    assign o_out_valid       = r_valid;
    assign o_fp_exce         = r_exc;
    assign o_op_is_exception = r_exc != EXC_NONE;
    assign o_default_result  = r_res;
    assign o_sticky_flags    = r_flags;
    assign o_exc_count       = r_cnt;
endmodule

// File: tb/tb_fp_exception_unit.sv
// tb_fp_exception_unit: table vectors, hand-written handshake/counter sequences and random stimulus
// checked against a class-based reference model of the exception rules.
module tb_fp_exception_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       flag_clr = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;

    logic       in_ready, out_valid, is_exc;
    logic [1:0] exce;
    logic [7:0] dres;
    logic [2:0] flags;
    logic [7:0] cnt;
    logic       in_ready2, out_valid2, is_exc2;
    logic [1:0] exce2;
    logic [7:0] dres2;
    logic [2:0] flags2;
    logic [1:0] cnt2;

    int n_cmp = 0;
    int n_err = 0;

    bit       m_valid;
    bit [1:0] m_exc;
    bit [7:0] m_res;
    bit [2:0] m_flags;
    int       m_cnt, m_cnt2;

    fp_exception_unit u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_fp_operation(op), .i_op_a(a), .i_op_b(b), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_op_is_exception(is_exc), .o_fp_exce(exce),
        .o_default_result(dres), .o_sticky_flags(flags), .o_exc_count(cnt), .i_flag_clr(flag_clr)
    );

    fp_exception_unit #(.CNT_W(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready2),
        .i_fp_operation(op), .i_op_a(a), .i_op_b(b), .o_out_valid(out_valid2),
        .i_out_ready(out_ready), .o_op_is_exception(is_exc2), .o_fp_exce(exce2),
        .o_default_result(dres2), .o_sticky_flags(flags2), .o_exc_count(cnt2), .i_flag_clr(flag_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int unsigned act, int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 zero, 1 finite nonzero, 2 inf, 3 NaN
    function automatic int cls(logic [7:0] x);
        if (x[6:3] == 4'hF) return (x[2:0] != 0) ? 3 : 2;
        if (x[6:0] == 0) return 0;
        return 1;
    endfunction

    function automatic void ref_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                                   output bit [1:0] e, output bit [7:0] r);
        int  ca = cls(x);
        int  cb = cls(y);
        bit  sa = x[7];
        bit  sb = y[7];
        bit  sbe = (o == 2'd1) ? ~y[7] : y[7];
        e = 0;
        r = 0;
        if (ca == 3 || cb == 3) begin e = 1; r = 8'h7C; end
        else if (o <= 2'd1) begin
            if (ca == 2 && cb == 2 && sa != sbe) begin e = 1; r = 8'h7C; end
            else if (ca == 2) begin e = 3; r = {sa, 7'h78}; end
            else if (cb == 2) begin e = 3; r = {sbe, 7'h78}; end
        end else if (o == 2'd2) begin
            if ((ca == 0 && cb == 2) || (ca == 2 && cb == 0)) begin e = 1; r = 8'h7C; end
            else if (ca == 2 || cb == 2) begin e = 3; r = {sa ^ sb, 7'h78}; end
        end else begin
            if ((ca == 0 && cb == 0) || (ca == 2 && cb == 2)) begin e = 1; r = 8'h7C; end
            else if (ca == 2) begin e = 3; r = {sa ^ sb, 7'h78}; end
            else if (cb == 2) begin e = 3; r = {sa ^ sb, 7'h00}; end
            else if (cb == 0) begin e = 2; r = {sa ^ sb, 7'h78}; end
        end
    endfunction

    task automatic check_all();
        chk("out_valid", out_valid, m_valid);
        chk("is_exception", is_exc, m_exc != 0);
        if (m_valid) begin
            chk("fp_exce", exce, m_exc);
            chk("default_result", dres, m_res);
        end
        chk("sticky_flags", flags, m_flags);
        chk("exc_count", cnt, m_cnt);
        chk("exc_count_w2", cnt2, m_cnt2);
    endtask

    task automatic tick();
        bit [1:0] e;
        bit [7:0] r;
        bit       fire;
        #1;
        chk("in_ready", in_ready, !m_valid || out_ready);
        if (!rst_n) begin
            m_valid = 0; m_exc = 0; m_res = 0; m_flags = 0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            fire = in_valid && (!m_valid || out_ready);
            ref_op(op, a, b, e, r);
            if (flag_clr) begin m_flags = 0; m_cnt = 0; m_cnt2 = 0; end
            if (fire && e != 0) begin
                m_flags[e-1] = 1'b1;
                m_cnt  = (m_cnt  < 255) ? m_cnt + 1 : 255;
                m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
            end
            if (fire) begin m_valid = 1; m_exc = e; m_res = r; end
            else if (out_ready) m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] exc;
        logic [7:0] res;
    } vec_t;

    vec_t vecs[16];
    logic [7:0] specials[10];

    initial begin
        logic [7:0] held;
        vecs[0]  = '{2'd0, 8'h78, 8'hF8, 2'd1, 8'h7C};
        vecs[1]  = '{2'd1, 8'hF8, 8'hF8, 2'd1, 8'h7C};
        vecs[2]  = '{2'd1, 8'hF8, 8'h78, 2'd3, 8'hF8};
        vecs[3]  = '{2'd1, 8'h38, 8'h38, 2'd0, 8'h00};
        vecs[4]  = '{2'd3, 8'hB8, 8'h00, 2'd2, 8'hF8};
        vecs[5]  = '{2'd3, 8'h00, 8'h80, 2'd1, 8'h7C};
        vecs[6]  = '{2'd3, 8'h38, 8'hF8, 2'd3, 8'h80};
        vecs[7]  = '{2'd2, 8'h80, 8'h78, 2'd1, 8'h7C};
        vecs[8]  = '{2'd2, 8'hB8, 8'h78, 2'd3, 8'hF8};
        vecs[9]  = '{2'd2, 8'h79, 8'h38, 2'd1, 8'h7C};
        vecs[10] = '{2'd0, 8'h38, 8'h78, 2'd3, 8'h78};
        vecs[11] = '{2'd1, 8'h38, 8'h78, 2'd3, 8'hF8};
        vecs[12] = '{2'd3, 8'hF8, 8'h80, 2'd3, 8'h78};
        vecs[13] = '{2'd3, 8'h38, 8'h00, 2'd2, 8'h78};
        vecs[14] = '{2'd3, 8'h00, 8'h38, 2'd0, 8'h00};
        vecs[15] = '{2'd2, 8'h38, 8'h38, 2'd0, 8'h00};
        specials = '{8'h00, 8'h80, 8'h78, 8'hF8, 8'h7C, 8'h79, 8'hFF, 8'h38, 8'hB8, 8'h01};

        // Reset with an offer pending: the offer must be discarded
        rst_n = 0; in_valid = 1; op = 2'd3; a = 8'hB8; b = 8'h00;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", cnt, 0);
        chk("rst_flags", flags, 0);
        chk("rst_result", dres, 0);
        rst_n = 1;

        for (int i = 0; i < 16; i++) begin
            in_valid = 1; out_ready = 1;
            op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            tick();
            chk($sformatf("vec%0d_exce", i), exce, vecs[i].exc);
            chk($sformatf("vec%0d_result", i), dres, vecs[i].res);
            chk($sformatf("vec%0d_is_exc", i), is_exc, vecs[i].exc != 0);
            if (i == 0) begin
                chk("first_flags", flags, 3'b001);
                chk("first_count", cnt, 1);
            end
        end
        in_valid = 0;
        tick();
        chk("drain_out_valid", out_valid, 0);

        // Back-pressure with an exception entry held
        in_valid = 1; op = 2'd3; a = 8'hB8; b = 8'h00;
        tick();
        held = dres;
        out_ready = 0; op = 2'd2; a = 8'h80; b = 8'h78;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_result_stable", dres, held);
            chk("bp_exce_stable", exce, 2'd2);
        end
        out_ready = 1;
        tick();
        chk("bp_release_exce", exce, 2'd1);

        // Clear together with an accepted divide-by-zero
        flag_clr = 1; op = 2'd3; a = 8'hB8; b = 8'h00;
        tick();
        flag_clr = 0;
        chk("clr_flags", flags, 3'b010);
        chk("clr_count", cnt, 1);

        // Counter saturation on the narrow instance
        rst_n = 0; in_valid = 0;
        tick();
        rst_n = 1; in_valid = 1; op = 2'd0; a = 8'h78; b = 8'hF8;
        for (int i = 0; i < 5; i++) tick();
        chk("sat_count_w2", cnt2, 3);
        chk("sat_count_w8", cnt, 5);

        // Reset mid-stream drops the held entry
        out_ready = 0;
        tick();
        rst_n = 0;
        tick();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_exce", exce, 0);
        chk("midrst_result", dres, 0);
        chk("midrst_count", cnt, 0);
        rst_n = 1; out_ready = 1;

        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            flag_clr  = ($urandom_range(15) == 0);
            rst_n     = ($urandom_range(49) != 0);
            op = 2'($urandom_range(3));
            a  = $urandom_range(1) ? specials[$urandom_range(9)] : 8'($urandom);
            b  = $urandom_range(1) ? specials[$urandom_range(9)] : 8'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
